// File: rtl/rob_commit.sv
// rob_commit -- in-order reorder buffer feeding the architectural RF write port.
//
// Decode allocates one entry per instruction at the tail, in program order.
// Execute marks entries done by tag, in any order. At most one completed head
// entry retires per cycle onto the single RF write port. Flush squashes
// everything in flight.
//
// Optional build macro: ROB_WB_BYPASS_EN
//   When defined, a writeback aimed at the not-yet-done head entry retires that
//   entry in the same cycle, with the writeback data forwarded to the RF port.
//   When undefined, such a writeback only sets done and the entry retires one
//   cycle later.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   alloc_valid/wen/rd             allocation request from decode
//   alloc_ready, alloc_idx         entry available / tag handed out (= tail)
//   wb_valid, wb_idx, wb_data      out-of-order result from execute
//   flush                          squash all entries (highest priority)
//   rf_wen, rf_rd, rf_rd_data      architectural RF write port
//   commit_valid                   an entry retires this cycle (writing or not)
//   rob_empty, rob_count           occupancy status

// One ROB slot. The top decodes the per-slot strobes from head/tail/wb_idx,
// so the slot only has to apply them in priority order.
module rob_entry #(
    parameter int RF_SIZE_LOG = 2,
    parameter int REG_LEN     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,        // flush: drop the entry
    input  logic                   retire,     // this slot is the committing head
    input  logic                   alloc_hit,  // this slot is the allocating tail
    input  logic                   alloc_wen,
    input  logic [RF_SIZE_LOG-1:0] alloc_rd,
    input  logic                   wb_hit,     // writeback addressed to this slot
    input  logic [REG_LEN-1:0]     wb_data,
    output logic                   valid,
    output logic                   done,
    output logic                   wen,
    output logic [RF_SIZE_LOG-1:0] rd,
    output logic [REG_LEN-1:0]     data
);

    // Retire beats a same-cycle writeback so a bypassed commit never leaves a
    // stale done bit behind. Alloc and retire can never target the same slot:
    // head == tail only when empty (nothing to retire) or full (no alloc).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            done  <= 1'b0;
            wen   <= 1'b0;
            rd    <= '0;
            data  <= '0;
        end else if (clr || retire) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (alloc_hit) begin
            valid <= 1'b1;
            done  <= 1'b0;
            wen   <= alloc_wen;
            rd    <= alloc_rd;
        end else if (wb_hit && valid && !done) begin
            // Late or duplicate results (invalid or already-done slot) are ignored.
            done <= 1'b1;
            data <= wb_data;
        end
    end

endmodule

module rob_commit #(
    parameter int ROB_SIZE_LOG = 2,
    parameter int RF_SIZE_LOG  = 2,
    parameter int REG_LEN      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic                    alloc_wen,
    input  logic [RF_SIZE_LOG-1:0]  alloc_rd,
    output logic                    alloc_ready,
    output logic [ROB_SIZE_LOG-1:0] alloc_idx,
    input  logic                    wb_valid,
    input  logic [ROB_SIZE_LOG-1:0] wb_idx,
    input  logic [REG_LEN-1:0]      wb_data,
    input  logic                    flush,
    output logic                    rf_wen,
    output logic [RF_SIZE_LOG-1:0]  rf_rd,
    output logic [REG_LEN-1:0]      rf_rd_data,
    output logic                    commit_valid,
    output logic                    rob_empty,
    output logic [ROB_SIZE_LOG:0]   rob_count
);

    localparam int                    ROB_SIZE = 2 ** ROB_SIZE_LOG;
    localparam logic [ROB_SIZE_LOG:0] FULL_CNT = (ROB_SIZE_LOG + 1)'(ROB_SIZE);
    localparam logic [ROB_SIZE_LOG:0] CNT_ONE  = (ROB_SIZE_LOG + 1)'(1);
    localparam logic [ROB_SIZE_LOG-1:0] PTR_ONE = ROB_SIZE_LOG'(1);

    logic [ROB_SIZE_LOG-1:0] head;
    logic [ROB_SIZE_LOG-1:0] tail;
    logic [ROB_SIZE_LOG:0]   count;

    logic [ROB_SIZE-1:0]                  e_valid;
    logic [ROB_SIZE-1:0]                  e_done;
    logic [ROB_SIZE-1:0]                  e_wen;
    logic [ROB_SIZE-1:0][RF_SIZE_LOG-1:0] e_rd;
    logic [ROB_SIZE-1:0][REG_LEN-1:0]     e_data;

    logic alloc_fire;
    logic head_ready;
    logic bypass;

    // Full means full even if the head retires this cycle: a freed slot is only
    // reusable from the next cycle on, which keeps alloc_ready off the commit path.
    assign alloc_ready = (count != FULL_CNT);
    assign alloc_idx   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;

    assign head_ready  = e_valid[head] && e_done[head];

`ifdef ROB_WB_BYPASS_EN
    assign bypass = e_valid[head] && !e_done[head] && wb_valid && (wb_idx == head);
`else
    assign bypass = 1'b0;
`endif

    assign commit_valid = (head_ready || bypass) && !flush;
    assign rf_wen       = commit_valid && e_wen[head];
    assign rf_rd        = e_rd[head];
    assign rf_rd_data   = bypass ? wb_data : e_data[head];

    assign rob_empty = (count == '0);
    assign rob_count = count;

    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
        localparam logic [ROB_SIZE_LOG-1:0] TAG = ROB_SIZE_LOG'(i);

        rob_entry #(
            .RF_SIZE_LOG (RF_SIZE_LOG),
            .REG_LEN     (REG_LEN)
        ) u_ent (
            .clk       (clk),
            .rst       (rst),
            .clr       (flush),
            .retire    (commit_valid && (head == TAG)),
            .alloc_hit (alloc_fire && (tail == TAG)),
            .alloc_wen (alloc_wen),
            .alloc_rd  (alloc_rd),
            .wb_hit    (wb_valid && !flush && (wb_idx == TAG)),
            .wb_data   (wb_data),
            .valid     (e_valid[i]),
            .done      (e_done[i]),
            .wen       (e_wen[i]),
            .rd        (e_rd[i]),
            .data      (e_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)   tail <= tail + PTR_ONE;
            if (commit_valid) head <= head + PTR_ONE;
            case ({alloc_fire, commit_valid})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Testbench for rob_commit: per-cycle vector table for in-order commit and
// full-ROB behaviour, a commit scoreboard fed at allocation time, and directed
// sequences for reset, wrap, flush and head-writeback timing.
module tb_rob_commit;

    localparam int RSL = 2;
    localparam int RFL = 2;
    localparam int RL  = 8;
`ifdef ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           alloc_valid, alloc_wen;
    logic [RFL-1:0] alloc_rd;
    logic           alloc_ready;
    logic [RSL-1:0] alloc_idx;
    logic           wb_valid;
    logic [RSL-1:0] wb_idx;
    logic [RL-1:0]  wb_data;
    logic           flush;
    logic           rf_wen;
    logic [RFL-1:0] rf_rd;
    logic [RL-1:0]  rf_rd_data;
    logic           commit_valid, rob_empty;
    logic [RSL:0]   rob_count;

    always #5 clk = ~clk;

    rob_commit #(.ROB_SIZE_LOG(RSL), .RF_SIZE_LOG(RFL), .REG_LEN(RL)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_wen(alloc_wen), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .flush(flush),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
        .commit_valid(commit_valid), .rob_empty(rob_empty), .rob_count(rob_count)
    );

    typedef struct {
        logic           wen;
        logic [RFL-1:0] rd;
        logic [RL-1:0]  data;
    } sb_t;

    sb_t sbq[$];

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_commit = 0;
    int n_rfw    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every retirement must match the oldest outstanding allocation.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && commit_valid) begin
            n_commit++;
            if (rf_wen) n_rfw++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL commit_unexpected: rd=%0d data=%0h, expected no commit (t=%0t)",
                         rf_rd, rf_rd_data, $time);
            end else begin
                e = sbq.pop_front();
                chk("commit_wen", 32'(rf_wen), 32'(e.wen));
                if (e.wen) begin
                    chk("commit_rd",   32'(rf_rd),      32'(e.rd));
                    chk("commit_data", 32'(rf_rd_data), 32'(e.data));
                end
            end
        end
    end

    task automatic drive(input logic av, input logic aw, input logic [RFL-1:0] ard,
                         input logic wv, input logic [RSL-1:0] wi, input logic [RL-1:0] wd,
                         input logic fl);
        alloc_valid = av;
        alloc_wen   = aw;
        alloc_rd    = ard;
        wb_valid    = wv;
        wb_idx      = wi;
        wb_data     = wd;
        flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_push(input logic aw, input logic [RFL-1:0] ard, input logic [RL-1:0] sd);
        drive(1'b1, aw, ard, 1'b0, '0, '0, 1'b0);
        sbq.push_back('{aw, ard, sd});
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sbq.delete();
        tick();
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        idle();
        while (!rob_empty && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!rob_empty) begin
            n_bad++;
            $display("FAIL drain_timeout: rob_count=%0d after %0d cycles, expected 0", rob_count, budget);
        end
    endtask

    typedef struct {
        logic           av, aw;
        logic [RFL-1:0] ard;
        logic [RL-1:0]  sd;     // data the bench will later write back for this entry
        logic           wv;
        logic [RSL-1:0] wi;
        logic [RL-1:0]  wd;
        logic           e_rdy;
        logic [RSL-1:0] e_idx;
        logic [RSL:0]   e_cnt;
        logic           e_cv;
    } vec_t;

    localparam int NV = 17;
    vec_t tv[NV];

    function automatic vec_t mk(input logic av, input logic [RFL-1:0] ard, input logic [RL-1:0] sd,
                                input logic wv, input logic [RSL-1:0] wi, input logic [RL-1:0] wd,
                                input logic e_rdy, input logic [RSL-1:0] e_idx,
                                input logic [RSL:0] e_cnt, input logic e_cv);
        vec_t v;
        v.av = av; v.aw = av; v.ard = ard; v.sd = sd;
        v.wv = wv; v.wi = wi; v.wd = wd;
        v.e_rdy = e_rdy; v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_cv = e_cv;
        return v;
    endfunction

    initial begin
        logic           w;
        int             base_c, base_w;

        // In-order commit: tags 0,1,2 -> r1,r2,r3; WB order 2,0,1.
        tv[0]  = mk(1'b1, 2'd1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 3'd0, 1'b0);
        tv[1]  = mk(1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 3'd1, 1'b0);
        tv[2]  = mk(1'b1, 2'd3, 8'h22, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd2, 1'b0);
        tv[3]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h22, 1'b1, 2'd3, 3'd3, 1'b0);
        tv[4]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 1'b1, 2'd3, 3'd3, BYP);
        tv[5]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, BYP ? 3'd2 : 3'd3, 1'b1);
        tv[6]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, BYP ? 3'd1 : 3'd2, 1'b1);
        tv[7]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, BYP ? 3'd0 : 3'd1, !BYP);
        tv[8]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 3'd0, 1'b0);
        // Fill to capacity (tags 3,0,1,2), 5th alloc dropped, then retire head tag 3.
        tv[9]  = mk(1'b1, 2'd0, 8'hA0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 3'd0, 1'b0);
        tv[10] = mk(1'b1, 2'd1, 8'hA1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 3'd1, 1'b0);
        tv[11] = mk(1'b1, 2'd2, 8'hA2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 3'd2, 1'b0);
        tv[12] = mk(1'b1, 2'd3, 8'hA3, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd3, 1'b0);
        tv[13] = mk(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 3'd4, 1'b0);
        tv[14] = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hA0, 1'b0, 2'd3, 3'd4, BYP);
        tv[15] = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, BYP, 2'd3, BYP ? 3'd3 : 3'd4, !BYP);
        tv[16] = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 3'd3, 1'b0);

        // Power-on reset state.
        idle();
        #12;
        chk("rst_alloc_ready",  32'(alloc_ready),  32'd1);
        chk("rst_alloc_idx",    32'(alloc_idx),    32'd0);
        chk("rst_rf_wen",       32'(rf_wen),       32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_rob_empty",    32'(rob_empty),    32'd1);
        chk("rst_rob_count",    32'(rob_count),    32'd0);
        chk("rst_rf_rd_data",   32'(rf_rd_data),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset with three entries in flight: asynchronous, takes effect at once.
        drive(1'b1, 1'b1, 2'd1, 1'b0, '0, '0, 1'b0); tick();
        drive(1'b1, 1'b1, 2'd2, 1'b0, '0, '0, 1'b0); tick();
        drive(1'b1, 1'b1, 2'd3, 1'b0, '0, '0, 1'b0); tick();
        idle();
        @(negedge clk);
        chk("midrst_pre_count", 32'(rob_count), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("midrst_count",       32'(rob_count),   32'd0);
        chk("midrst_empty",       32'(rob_empty),   32'd1);
        chk("midrst_rf_wen",      32'(rf_wen),      32'd0);
        chk("midrst_alloc_ready", 32'(alloc_ready), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_alloc_idx", 32'(alloc_idx), 32'd0);
        tick();

        // Vector table: in-order commit, then full ROB.
        for (int r = 0; r < NV; r++) begin
            drive(tv[r].av, tv[r].aw, tv[r].ard, tv[r].wv, tv[r].wi, tv[r].wd, 1'b0);
            if (tv[r].av && tv[r].e_rdy) sbq.push_back('{tv[r].aw, tv[r].ard, tv[r].sd});
            @(negedge clk);
            chk($sformatf("vec%0d_alloc_ready", r),  32'(alloc_ready),  32'(tv[r].e_rdy));
            chk($sformatf("vec%0d_alloc_idx", r),    32'(alloc_idx),    32'(tv[r].e_idx));
            chk($sformatf("vec%0d_rob_count", r),    32'(rob_count),    32'(tv[r].e_cnt));
            chk($sformatf("vec%0d_rob_empty", r),    32'(rob_empty),    32'(tv[r].e_cnt == 3'd0));
            chk($sformatf("vec%0d_commit_valid", r), 32'(commit_valid), 32'(tv[r].e_cv));
            chk($sformatf("vec%0d_rf_wen", r),       32'(rf_wen),       32'(tv[r].e_cv));
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 2'd0, 8'hA1, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd1, 8'hA2, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd2, 8'hA3, 1'b0); tick();
        wait_empty(20);

        // Wrap: ten alloc/WB/commit rounds, wen alternating.
        do_reset();
        base_c = n_commit;
        base_w = n_rfw;
        for (int i = 0; i < 10; i++) begin
            w = (i % 2 == 0);
            chk($sformatf("wrap%0d_tag", i),   32'(alloc_idx), 32'(i % 4));
            chk($sformatf("wrap%0d_count", i), 32'(rob_count), 32'd0);
            alloc_push(w, 2'(i), 8'(8'h30 + 8'(i)));
            tick();
            drive(1'b0, 1'b0, '0, 1'b1, 2'(i), 8'(8'h30 + 8'(i)), 1'b0);
            tick();
            idle();
            tick();
        end
        chk("wrap_commits", 32'(n_commit - base_c), 32'd10);
        chk("wrap_rf_writes", 32'(n_rfw - base_w), 32'd5);

        // Flush with head done: tail starts at 2, so tags 2,3,0.
        alloc_push(1'b1, 2'd1, 8'h77); tick();
        alloc_push(1'b1, 2'd2, 8'h78); tick();
        alloc_push(1'b1, 2'd3, 8'h79); tick();
        if (!BYP) begin
            drive(1'b0, 1'b0, '0, 1'b1, 2'd2, 8'h77, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 2'd2, 8'h77, 1'b1);
        sbq.delete();
        @(negedge clk);
        chk("flush_commit_valid", 32'(commit_valid), 32'd0);
        chk("flush_rf_wen",       32'(rf_wen),       32'd0);
        tick();
        idle();
        chk("flush_count",     32'(rob_count), 32'd0);
        chk("flush_empty",     32'(rob_empty), 32'd1);
        chk("flush_alloc_idx", 32'(alloc_idx), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b1, 2'd1, 8'hEE, 1'b0); tick();   // stale WB
        alloc_push(1'b1, 2'd2, 8'h61); tick();
        alloc_push(1'b1, 2'd3, 8'h62); tick();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd0, 8'h61, 1'b0); tick();
        idle(); tick();
        @(negedge clk);
        chk("post_flush_tag1_waits", 32'(commit_valid), 32'd0);
        chk("post_flush_count",      32'(rob_count),    32'd1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd1, 8'h62, 1'b0); tick();
        wait_empty(10);

        // Writeback to a lone head entry: same-cycle commit only with bypass.
        do_reset();
        alloc_push(1'b1, 2'd3, 8'h5A); tick();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd0, 8'h5A, 1'b0);
        @(negedge clk);
        chk("byp_wb_cycle_rf_wen", 32'(rf_wen), 32'(BYP));
        if (BYP) begin
            chk("byp_wb_cycle_data", 32'(rf_rd_data), 32'h5A);
            chk("byp_wb_cycle_rd",   32'(rf_rd),      32'd3);
        end
        tick();
        idle();
        @(negedge clk);
        chk("byp_next_cycle_rf_wen", 32'(rf_wen), 32'(!BYP));
        if (!BYP) chk("byp_next_cycle_data", 32'(rf_rd_data), 32'h5A);
        tick();
        chk("byp_final_count", 32'(rob_count), 32'd0);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
